// File: rtl/uart_rx_wb_pkg.sv
// Shared constants for the UART receiver: register map, STATUS bit positions
// and receive FSM states.
package uart_rx_wb_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_OVERRUN   = 7;
    localparam int STAT_FRAME_ERR = 6;
    localparam int DATA_VALID     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_wb_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_L);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with a receive FIFO, read by the CPU through a
// Wishbone-classic slave with DATA and STATUS registers.
module uart_rx_wb
    import uart_rx_wb_pkg::*;
#(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic        wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        irq
);
    localparam int DW = $clog2(DIVISOR);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DW-1:0] DIV_HALF = DW'(DIVISOR/2 - 1);
    localparam logic [DW-1:0] DIV_FULL = DW'(DIVISOR - 1);

    logic            rx_meta;
    logic            rx_sync;
    rx_state_t       state;
    logic [DW-1:0]   div_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            push_q;
    logic            ferr_q;
    logic            tick;

    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    logic            overrun;
    logic            frame_err;
    logic            pop_pend;
    logic            wb_req;
    logic            stat_wr;
    logic [31:0]     rd_data;
    logic [31:0]     cnt_ext;
    logic [3:0]      cnt_sat;
    logic            unused_dat;

    assign unused_dat = ^{wb_dat_i[31:8], wb_dat_i[5:0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    assign tick = (div_cnt == '0);

    // Sampling happens mid-bit: START waits half a bit, every later bit a full one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        div_cnt <= DIV_HALF;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!rx_sync) begin
                            state   <= ST_DATA;
                            div_cnt <= DIV_FULL;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg[bit_cnt] <= rx_sync;
                        div_cnt        <= DIV_FULL;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        push_q <= rx_sync;
                        ferr_q <= ~rx_sync;
                        state  <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push_q),
        .pop   (pop_pend),
        .din   (shreg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wb_req  = wb_cyc & wb_stb & ~wb_ack;
    assign stat_wr = wb_req & wb_we & (wb_adr == ADDR_STATUS);
    assign cnt_ext = 32'(fifo_count);
    assign cnt_sat = (cnt_ext > 32'd15) ? 4'hf : cnt_ext[3:0];

    always_comb begin
        rd_data = '0;
        if (wb_adr == ADDR_STATUS) begin
            rd_data[STAT_OVERRUN]   = overrun;
            rd_data[STAT_FRAME_ERR] = frame_err;
            rd_data[3:0]            = cnt_sat;
        end else if (!fifo_empty) begin
            rd_data[DATA_VALID] = 1'b1;
            rd_data[7:0]        = fifo_dout;
        end
    end

    // Data is captured on the request cycle; the pop lands on the ack cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_ack    <= 1'b0;
            wb_dat_o  <= '0;
            pop_pend  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            wb_ack    <= wb_req;
            wb_dat_o  <= (wb_req & ~wb_we) ? rd_data : '0;
            pop_pend  <= wb_req & ~wb_we & (wb_adr == ADDR_DATA) & ~fifo_empty;
            overrun   <= (push_q & fifo_full & ~pop_pend) |
                         (overrun & ~(stat_wr & wb_dat_i[7]));
            frame_err <= ferr_q | (frame_err & ~(stat_wr & wb_dat_i[6]));
            irq       <= (fifo_count != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// Randomised and directed bench for uart_rx_wb with a queue-based model of
// the receive FIFO and status flags.
module tb_uart_rx_wb;
    localparam int DIV = 8;
    localparam logic A_DATA = 1'b0;
    localparam logic A_STAT = 1'b1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RX = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_adr = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        irq;

    int errors = 0;
    int checks = 0;

    uart_rx_wb #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX(RX),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .irq(irq)
    );

    always #7 CLK = ~CLK;

    // All drivers assume entry just after a rising edge and return likewise.
    task automatic wb_read(input logic adr, output logic [31:0] d, output logic ack);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
        @(posedge CLK); #1;
        ack = wb_ack; d = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic wb_write(input logic adr, input logic [31:0] v);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat_i = v;
        @(posedge CLK); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_dat_i = '0;
        @(posedge CLK); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            RX = fr[i];
            repeat (DIV-1) @(posedge CLK);
        end
        @(posedge CLK); #1;
        RX = 1'b1;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic a;
        repeat (3) @(posedge CLK); #1;
        checks++; if ({wb_ack, irq} !== 2'b00 || wb_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: ack=%b irq=%b dat=%h want 0/0/0", wb_ack, irq, wb_dat_o);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
        wb_read(A_STAT, d, a);
        checks++; if (a !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL reset_status: ack=%b dat=%h want 1/00000000", a, d);
        end
        checks++; if (wb_ack !== 1'b0) begin
            errors++; $display("FAIL ack_pulse: ack=%b want 0", wb_ack);
        end
        wb_read(A_DATA, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL reset_data: dat=%h want 0", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic a;
        send_byte(8'hA5, 1'b1, 4);
        checks++; if (irq !== 1'b1) begin
            errors++; $display("FAIL basic_irq_rise: irq=%b want 1", irq);
        end
        wb_read(A_DATA, d, a);
        checks++; if (a !== 1'b1 || d !== 32'h1A5) begin
            errors++; $display("FAIL basic_read: ack=%b dat=%h want 1/000001a5", a, d);
        end
        wb_read(A_DATA, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL basic_empty: dat=%h want 0", d);
        end
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL basic_irq_fall: irq=%b want 0", irq);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d; logic a;
        @(posedge CLK); #1; RX = 1'b0;
        @(posedge CLK); #1; RX = 1'b1;
        repeat (20) @(posedge CLK); #1;
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL glitch_status: dat=%h irq=%b want 0/0", d, irq);
        end
        send_byte(8'hC3, 1'b1, 4);
        wb_read(A_DATA, d, a);
        checks++; if (d !== 32'h1C3) begin
            errors++; $display("FAIL glitch_rearm: dat=%h want 000001c3", d);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d; logic a;
        send_byte(8'h3C, 1'b0, 16);
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h40) begin
            errors++; $display("FAIL ferr_status: dat=%h want 00000040", d);
        end
        wb_read(A_DATA, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL ferr_discard: dat=%h want 0", d);
        end
        wb_write(A_STAT, 32'h40);
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL ferr_clear: dat=%h want 0", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d; logic a;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 2);
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h84) begin
            errors++; $display("FAIL ovr_status: dat=%h want 00000084", d);
        end
        for (int i = 1; i <= 5; i++) begin
            wb_read(A_DATA, d, a);
            checks++; if (d !== ((i <= 4) ? (32'h100 | 32'(i)) : 32'h0)) begin
                errors++; $display("FAIL ovr_drain%0d: dat=%h", i, d);
            end
        end
        wb_write(A_STAT, 32'h80);
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL ovr_clear: dat=%h want 0", d);
        end
    endtask

    // The read is timed so its pop coincides with the 5th byte's push.
    task automatic test_push_pop_full();
        logic [31:0] d, d0; logic a, a0;
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 2);
        fork
            send_byte(8'h15, 1'b1, 8);
            begin
                @(posedge CLK);
                repeat (78) @(posedge CLK);
                #1;
                wb_read(A_DATA, d0, a0);
            end
        join
        checks++; if (d0 !== 32'h111) begin
            errors++; $display("FAIL pp_read: dat=%h want 00000111", d0);
        end
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h04) begin
            errors++; $display("FAIL pp_status: dat=%h want 00000004", d);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(A_DATA, d, a);
            checks++; if (d !== (32'h112 + 32'(i))) begin
                errors++; $display("FAIL pp_drain%0d: dat=%h want %h", i, d, 32'h112 + 32'(i));
            end
        end
    endtask

    task automatic test_random();
        byte unsigned q[$];
        logic mo, mf, bad, a;
        logic [7:0] b, clr;
        logic [31:0] d, exp;
        int gap;
        mo = 1'b0; mf = 1'b0;
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            gap = bad ? 16 : (($urandom_range(0, 2) == 0) ? 0 : 4);
            send_byte(b, ~bad, gap);
            if (bad)              mf = 1'b1;
            else if (q.size() < 4) q.push_back(b);
            else                  mo = 1'b1;
            if (gap != 0) begin
                for (int r = $urandom_range(0, 2); r > 0; r--) begin
                    if ($urandom_range(0, 1) == 1) begin
                        wb_read(A_STAT, d, a);
                        exp = {24'b0, mo, mf, 2'b0, 4'(q.size())};
                    end else begin
                        wb_read(A_DATA, d, a);
                        exp = (q.size() != 0) ? {23'b0, 1'b1, q.pop_front()} : 32'h0;
                    end
                    checks++; if (d !== exp) begin
                        errors++; $display("FAIL rnd_read%0d: dat=%h want %h", n, d, exp);
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    clr = 8'($urandom) & 8'hC0;
                    wb_write(A_STAT, {24'b0, clr});
                    if (clr[7]) mo = 1'b0;
                    if (clr[6]) mf = 1'b0;
                end
                @(posedge CLK); #1;
                checks++; if (irq !== (q.size() != 0)) begin
                    errors++; $display("FAIL rnd_irq%0d: irq=%b want %b", n, irq, q.size() != 0);
                end
            end
        end
        wb_read(A_STAT, d, a);
        exp = {24'b0, mo, mf, 2'b0, 4'(q.size())};
        checks++; if (d !== exp) begin
            errors++; $display("FAIL rnd_status: dat=%h want %h", d, exp);
        end
        while (q.size() != 0) begin
            wb_read(A_DATA, d, a);
            exp = {23'b0, 1'b1, q.pop_front()};
            checks++; if (d !== exp) begin
                errors++; $display("FAIL rnd_drain: dat=%h want %h", d, exp);
            end
        end
        wb_write(A_STAT, 32'hC0);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d; logic a;
        logic [9:0] fr;
        send_byte(8'h77, 1'b1, 4);
        send_byte(8'h12, 1'b0, 16);
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h41) begin
            errors++; $display("FAIL mid_pre_status: dat=%h want 00000041", d);
        end
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            RX = fr[i];
            repeat (DIV-1) @(posedge CLK);
        end
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_STAT;
        RST_N = 1'b0; RX = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL mid_async_irq: irq=%b want 0", irq);
        end
        @(posedge CLK); #1;
        checks++; if (wb_ack !== 1'b0 || wb_dat_o !== 32'h0) begin
            errors++; $display("FAIL mid_no_ack: ack=%b dat=%h want 0/0", wb_ack, wb_dat_o);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (4) @(posedge CLK); #1;
        wb_read(A_STAT, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL mid_status: dat=%h want 0", d);
        end
        send_byte(8'h66, 1'b1, 4);
        wb_read(A_DATA, d, a);
        checks++; if (d !== 32'h166) begin
            errors++; $display("FAIL mid_rx: dat=%h want 00000166", d);
        end
        wb_read(A_DATA, d, a);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL mid_empty: dat=%h want 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_push_pop_full();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
